// File: rtl/sticky_event_latch.sv
// sticky_event_latch
//
// Captures rising edges on a bank of level event inputs into sticky status
// bits, counts occurrences per source with saturating counters (flagging a
// sticky overflow when a count would pass its maximum), and raises a
// registered, maskable interrupt. Software clears selected sources through a
// four-phase req/ack handshake.
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   rst_n     : asynchronous active-low reset
//   evt_in    : [WIDTH] level event inputs; a 0->1 transition is one event
//   irq_mask  : [WIDTH] 1 = source contributes to irq (capture is never gated)
//   clr_req   : clear request, held high until clr_ack is seen
//   clr_sel   : [WIDTH] sources to clear, captured when the request is accepted
//   clr_ack   : clear acknowledge, high while the handshake is in HOLD
//   status    : [WIDTH] sticky captured-event bits
//   ovf       : [WIDTH] sticky counter-overflow bits
//   count     : [WIDTH*CNT_W] occurrence counts, source i at [i*CNT_W +: CNT_W]
//   irq       : registered OR of (status & irq_mask)

module sticky_event_latch #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       evt_in,
    input  logic [WIDTH-1:0]       irq_mask,
    input  logic                   clr_req,
    input  logic [WIDTH-1:0]       clr_sel,
    output logic                   clr_ack,
    output logic [WIDTH-1:0]       status,
    output logic [WIDTH-1:0]       ovf,
    output logic [WIDTH*CNT_W-1:0] count,
    output logic                   irq
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        HOLD  = 2'd2
    } clr_state_t;

    clr_state_t       state_reg;
    clr_state_t       state_next;

    logic [WIDTH-1:0] evt_q_reg;
    logic [WIDTH-1:0] sel_reg;
    logic [WIDTH-1:0] status_reg;
    logic [WIDTH-1:0] status_next;
    logic [WIDTH-1:0] ovf_reg;
    logic [WIDTH-1:0] ovf_next;
    logic [CNT_W-1:0] cnt_reg  [WIDTH];
    logic [CNT_W-1:0] cnt_next [WIDTH];
    logic             clr_ack_reg;
    logic             irq_reg;

    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] clr_bit;
    logic             clear_now;

    // The clear is applied on the edge that leaves CLEAR, using the selection
    // captured when the request was accepted.
    assign clear_now = (state_reg == CLEAR);

    // ------------------------------------------------------------------
    // Clear handshake FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (clr_req) state_next = CLEAR;
            // CLEAR always advances so a request dropped early still sees
            // exactly one clear and a (short) acknowledge.
            CLEAR:   state_next = HOLD;
            HOLD:    if (!clr_req) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Per-source next-state logic
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_src
            assign rise[gi]    = evt_in[gi] & ~evt_q_reg[gi];
            assign clr_bit[gi] = clear_now & sel_reg[gi];

            // A rise in the clear cycle wins: status stays set and the count
            // restarts at one rather than zero.
            assign status_next[gi] = rise[gi] | (status_reg[gi] & ~clr_bit[gi]);

            // Overflow marks a rise that arrived while already saturated. A
            // cleared counter is zero, so a simultaneous rise cannot overflow.
            assign ovf_next[gi] = clr_bit[gi] ? 1'b0
                                : (ovf_reg[gi] | (rise[gi] & (cnt_reg[gi] == CNT_MAX)));

            assign cnt_next[gi] = clr_bit[gi] ? CNT_W'(rise[gi])
                                : ((rise[gi] && (cnt_reg[gi] != CNT_MAX)) ? cnt_reg[gi] + 1'b1
                                                                          : cnt_reg[gi]);

            assign count[gi*CNT_W +: CNT_W] = cnt_reg[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            evt_q_reg   <= '0;
            sel_reg     <= '0;
            status_reg  <= '0;
            ovf_reg     <= '0;
            clr_ack_reg <= 1'b0;
            irq_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            evt_q_reg   <= evt_in;
            status_reg  <= status_next;
            ovf_reg     <= ovf_next;
            clr_ack_reg <= (state_next == HOLD);
            // irq follows status/mask with one cycle of latency.
            irq_reg     <= |(status_reg & irq_mask);
            if (state_reg == IDLE && clr_req) begin
                sel_reg <= clr_sel;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cnt
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg[gi] <= '0;
                end else begin
                    cnt_reg[gi] <= cnt_next[gi];
                end
            end
        end
    endgenerate

    assign status  = status_reg;
    assign ovf     = ovf_reg;
    assign clr_ack = clr_ack_reg;
    assign irq     = irq_reg;

endmodule

// File: tb/tb_sticky_event_latch.sv
module tb_sticky_event_latch;

    localparam int W  = 8;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [W-1:0]    evt_in   = '0;
    logic [W-1:0]    irq_mask = '0;
    logic            clr_req  = 1'b0;
    logic [W-1:0]    clr_sel  = '0;
    logic            clr_ack;
    logic [W-1:0]    status;
    logic [W-1:0]    ovf;
    logic [W*CW-1:0] count;
    logic            irq;

    int checks = 0;
    int errors = 0;

    sticky_event_latch #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .evt_in   (evt_in),
        .irq_mask (irq_mask),
        .clr_req  (clr_req),
        .clr_sel  (clr_sel),
        .clr_ack  (clr_ack),
        .status   (status),
        .ovf      (ovf),
        .count    (count),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: per-source bookkeeping with plain integers, plus a
    // count of how far the current clear request has progressed
    // (0 = none, 1 = accepted/clearing, 2 = acknowledged).
    // ------------------------------------------------------------------
    logic [W-1:0] m_status, m_ovf, m_prev, m_sel;
    int           m_cnt [W];
    int           m_phase;
    logic         m_ack, m_irq;

    task automatic model_reset();
        m_status = '0;
        m_ovf    = '0;
        m_prev   = '0;
        for (int i = 0; i < W; i++) m_cnt[i] = 0;
        m_phase  = 0;
        m_ack    = 1'b0;
        m_irq    = 1'b0;
    endtask

    task automatic model_step();
        logic [W-1:0] old_status;
        old_status = m_status;
        for (int i = 0; i < W; i++) begin
            if (m_phase == 1 && m_sel[i]) begin
                m_status[i] = 1'b0;
                m_ovf[i]    = 1'b0;
                m_cnt[i]    = 0;
            end
            if (evt_in[i] && !m_prev[i]) begin
                m_status[i] = 1'b1;
                if (m_cnt[i] == (1 << CW) - 1) m_ovf[i] = 1'b1;
                else                           m_cnt[i] = m_cnt[i] + 1;
            end
        end
        m_irq = |(old_status & irq_mask);
        if (m_phase == 0 && clr_req) begin
            m_phase = 1;
            m_sel   = clr_sel;
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (m_phase == 2 && !clr_req) begin
            m_phase = 0;
        end
        m_ack  = (m_phase == 2);
        m_prev = evt_in;
    endtask

    function automatic logic [W*CW-1:0] m_count_packed();
        logic [W*CW-1:0] p;
        p = '0;
        for (int i = 0; i < W; i++) p[i*CW +: CW] = CW'(m_cnt[i]);
        return p;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check_val("status",  64'(status),  64'(m_status));
        check_val("ovf",     64'(ovf),     64'(m_ovf));
        check_val("count",   64'(count),   64'(m_count_packed()));
        check_val("irq",     64'(irq),     64'(m_irq));
        check_val("clr_ack", 64'(clr_ack), 64'(m_ack));
    endtask

    // One clock: model advances on the rising edge, outputs compared on the
    // falling edge. Inputs are only changed while clk is low.
    task automatic tick();
        logic ack_before;
        ack_before = m_ack;
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        check_all();
        if (m_ack && !ack_before)
            $display("clear ack  sel=%h status=%h ovf=%h count=%h", m_sel, status, ovf, count);
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_val("rst_status",  64'(status),  64'(0));
        check_val("rst_count",   64'(count),   64'(0));
        check_val("rst_clr_ack", 64'(clr_ack), 64'(0));
        check_val("rst_irq",     64'(irq),     64'(0));
        check_val("rst_ovf",     64'(ovf),     64'(0));
        $display("reset      applied");
    endtask

    initial begin
        #1;
        rst_n = 1'b0;
        model_reset();
        m_sel = '0;
        @(negedge clk);
        check_all();
        check_val("reset_status", 64'(status), 64'(0));
        rst_n = 1'b1;

        // Single held level -> one event, sticky after release.
        tick();
        evt_in = 8'h01;
        tick();
        check_val("hold_status", 64'(status), 64'h01);
        repeat (4) tick();
        check_val("hold_count0", 64'(count[3:0]), 64'd1);
        check_val("hold_ovf",    64'(ovf), 64'h00);
        evt_in = 8'h00;
        tick();
        check_val("sticky_status", 64'(status), 64'h01);
        $display("txn        level hold status=%h count=%h", status, count);

        // irq masking.
        irq_mask = 8'h01;
        tick();
        check_val("irq_on", 64'(irq), 64'd1);
        irq_mask = 8'h00;
        tick();
        check_val("irq_off", 64'(irq), 64'd0);
        check_val("irq_off_status", 64'(status), 64'h01);
        $display("txn        irq mask irq=%b status=%h", irq, status);

        // Saturation on source 3.
        for (int k = 0; k < 16; k++) begin
            evt_in = 8'h08; tick();
            evt_in = 8'h00; tick();
            if (k == 14) begin
                check_val("cnt3_at15", 64'(count[15:12]), 64'd15);
                check_val("ovf3_pre",  64'(ovf[3]), 64'd0);
            end
        end
        check_val("cnt3_sat", 64'(count[15:12]), 64'd15);
        check_val("ovf3_set", 64'(ovf[3]), 64'd1);
        evt_in = 8'h08; tick();
        evt_in = 8'h00; tick();
        check_val("cnt3_17th", 64'(count[15:12]), 64'd15);
        $display("txn        saturate count=%h ovf=%h", count, ovf);

        // Clear everything, then build status 0x05 and clear source 0.
        clr_req = 1'b1; clr_sel = 8'hFF;
        tick(); tick();
        clr_req = 1'b0;
        tick();
        check_val("clrall_status", 64'(status), 64'h00);
        check_val("clrall_ovf",    64'(ovf), 64'h00);
        evt_in = 8'h05; tick();
        evt_in = 8'h00; tick();
        check_val("pre_clr_status", 64'(status), 64'h05);
        clr_req = 1'b1; clr_sel = 8'h01;
        tick();
        check_val("ack_clear_phase", 64'(clr_ack), 64'd0);
        clr_sel = 8'hFF;   // must be ignored, selection already captured
        tick();
        check_val("ack_rise", 64'(clr_ack), 64'd1);
        check_val("clr_status", 64'(status), 64'h04);
        clr_req = 1'b0;
        tick();
        check_val("ack_fall", 64'(clr_ack), 64'd0);
        check_val("clr_status_kept", 64'(status), 64'h04);

        // Rise on source 2 during the CLEAR cycle wins.
        clr_req = 1'b1; clr_sel = 8'h04;
        tick();
        evt_in = 8'h04;
        tick();
        check_val("sbc_status2", 64'(status[2]), 64'd1);
        check_val("sbc_count2",  64'(count[11:8]), 64'd1);
        check_val("sbc_ovf2",    64'(ovf[2]), 64'd0);
        clr_req = 1'b0; evt_in = 8'h00;
        tick();

        // Reset in the middle of a handshake, request still high on release.
        clr_req = 1'b1; clr_sel = 8'hFF;
        tick(); tick();
        check_val("mid_ack", 64'(clr_ack), 64'd1);
        evt_in = 8'h02;
        tick();
        async_reset();
        tick();
        rst_n = 1'b1;
        tick();
        check_val("post_rst_status", 64'(status), 64'h02);
        tick();
        tick();
        check_val("restart_ack", 64'(clr_ack), 64'd1);
        clr_req = 1'b0;
        tick();
        evt_in = 8'h00;
        tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            evt_in = evt_in ^ W'($urandom & $urandom);
            if ($urandom_range(0, 9) == 0) irq_mask = W'($urandom);
            if (!clr_req && !m_ack && $urandom_range(0, 5) == 0) begin
                clr_req = 1'b1;
                clr_sel = W'($urandom);
            end else if (clr_req && m_ack) begin
                clr_req = 1'b0;
            end else if (clr_req && $urandom_range(0, 19) == 0) begin
                clr_req = 1'b0;
            end
            if ($urandom_range(0, 249) == 0) begin
                async_reset();
                tick();
                rst_n = 1'b1;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sticky_event_latch.md
STICKY_EVENT_LATCH -- requirements
Module: sticky_event_latch

Interface
REQ-001 Parameter WIDTH, default 8: number of event sources.
REQ-002 Parameter CNT_W, default 4: width of each per-source saturating occurrence counter.
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous assert, active-low; deassertion synchronous to clk by the environment.
REQ-005 Port evt_in  input  WIDTH: level event inputs, synchronous to clk; a source fires on a 0->1 transition.
REQ-006 Port irq_mask  input  WIDTH: 1 = source enabled for irq; does not gate capture.
REQ-007 Port clr_req  input  1: four-phase clear request, held high until clr_ack seen.
REQ-008 Port clr_sel  input  WIDTH: sources to clear; sampled only on clr_req acceptance.
REQ-009 Port clr_ack  output  1: four-phase clear acknowledge.
REQ-010 Port status  output  WIDTH: sticky captured-event bits.
REQ-011 Port ovf  output  WIDTH: sticky, set when a source's counter would exceed its maximum value.
REQ-012 Port count  output  WIDTH*CNT_W: per-source occurrence counts, source i at bits [i*CNT_W +: CNT_W].
REQ-013 Port irq  output  1: registered OR of (status & irq_mask).

Function
REQ-014 Edge detect: per source, a registered copy evt_q; rise[i] = evt_in[i] & ~evt_q[i]; a level held high produces exactly one rise.
REQ-015 Capture: a rise sets status[i] on the same clock edge that registers evt_q; status visible one cycle after the 0->1 transition is sampled.
REQ-016 Stickiness: status[i] remains 1 after evt_in[i] returns to 0 until cleared by REQ-019.
REQ-017 Counter: each rise increments count[i] by 1; at 2^CNT_W-1 the count saturates (no wrap) and ovf[i] is set.
REQ-018 ovf[i] is sticky and is cleared only together with status[i] by REQ-019.
REQ-019 Clear FSM states IDLE, CLEAR, HOLD; IDLE->CLEAR when clr_req=1; in CLEAR, latch clr_sel, zero status/ovf/count for selected bits, go HOLD; HOLD drives clr_ack=1 and returns to IDLE when clr_req=0.
REQ-020 clr_ack is registered, 0 in IDLE and CLEAR, 1 in HOLD; two cycles from clr_req rise to clr_ack rise.
REQ-021 Set beats clear: a rise on source i in the CLEAR cycle leaves status[i]=1 and count[i]=1, ovf[i]=0.
REQ-022 Unselected sources are unaffected by a clear, including ongoing counting.
REQ-023 clr_req dropping before clr_ack (protocol violation): FSM completes CLEAR, enters HOLD, exits next cycle; clear is still applied once.
REQ-024 irq is updated one cycle after status or irq_mask changes; irq_mask changes never alter status.
REQ-025 No output is X/Z at any time after the first reset, regardless of prior input history.

Reset
REQ-026 rst_n=0 asynchronously forces status=0, ovf=0, count=0, evt_q=0, irq=0, clr_ack=0, FSM=IDLE.
REQ-027 Reset asserted mid-handshake aborts it; after release with clr_req still high, a new clear starts from IDLE.
REQ-028 evt_in already high when rst_n releases counts as a rise on the first clock (evt_q reset to 0).

Verification
REQ-029 Reset, evt_in=8'h00, then evt_in[0]=1 for 5 cycles -> status=8'h01, count[0]=1, ovf=0; evt_in back to 0 -> status stays 8'h01.
REQ-030 irq_mask=8'h01, rise on source 0 -> irq=1 one cycle after status; irq_mask=8'h00 -> irq=0 next cycle, status unchanged.
REQ-031 16 rises on source 3 (CNT_W=4) -> count[3]=15, ovf[3]=1 after the 16th; a 17th rise leaves count[3]=15.
REQ-032 status=8'h05, clr_req=1 with clr_sel=8'h01 -> clr_ack=1 two cycles later, status=8'h04; clr_req=0 -> clr_ack=0 next cycle.
REQ-033 Rise on source 2 in CLEAR cycle with clr_sel=8'h04 -> status[2]=1, count[2]=1 after handshake.
REQ-034 rst_n pulsed low while clr_ack=1 and evt_in=8'h02 -> all outputs 0 immediately; first clock after release -> status=8'h02.
